// File: rtl/ahb_bus_arbiter_if.sv
// Master-side request buses and shared slave-side bus of the AHB-Lite arbiter.
// The master modport is the requester/bus environment; the slave modport is the arbiter.
`ifndef AHB_TRANS_BITS
`define AHB_TRANS_BITS 2
`endif
`ifndef AHB_SIZE_BITS
`define AHB_SIZE_BITS 3
`endif

interface ahb_bus_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int MW          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
);
  logic [NUM_MASTERS-1:0]                     HReq_m;
  logic [NUM_MASTERS-1:0]                     HLock_m;
  logic [32*NUM_MASTERS-1:0]                  HAddress_m;
  logic [`AHB_TRANS_BITS*NUM_MASTERS-1:0]     HTrans_m;
  logic [`AHB_SIZE_BITS*NUM_MASTERS-1:0]      HSize_m;
  logic [NUM_MASTERS-1:0]                     HWrite_m;
  logic [32*NUM_MASTERS-1:0]                  HWrite_data_m;
  logic                                       HReady;

  logic [NUM_MASTERS-1:0]                     HGrant;
  logic [MW-1:0]                              HMaster;
  logic                                       HMastLock;
  logic [31:0]                                HAddress;
  logic [`AHB_TRANS_BITS-1:0]                 HTrans;
  logic [`AHB_SIZE_BITS-1:0]                  HSize;
  logic                                       HWrite;
  logic [31:0]                                HWrite_data;

  modport master (
    output HReq_m, HLock_m, HAddress_m, HTrans_m, HSize_m, HWrite_m, HWrite_data_m, HReady,
    input  HGrant, HMaster, HMastLock, HAddress, HTrans, HSize, HWrite, HWrite_data
  );

  modport slave (
    input  HReq_m, HLock_m, HAddress_m, HTrans_m, HSize_m, HWrite_m, HWrite_data_m, HReady,
    output HGrant, HMaster, HMastLock, HAddress, HTrans, HSize, HWrite, HWrite_data
  );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB-Lite bus arbiter with lock support and a per-master hold cap,
// plus the address/control mux and the data-phase write-data mux.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int MAX_HOLD    = 16,
  parameter int MW          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  ahb_bus_arbiter_if.slave  bus
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TB = `AHB_TRANS_BITS;
  localparam int SB = `AHB_SIZE_BITS;

  typedef enum logic {IDLE, OWNED} state_e;
  typedef logic [NUM_MASTERS-1:0] vec_t;
  typedef logic [MW-1:0]          idx_t;

  function automatic vec_t onehot(input idx_t i);
    vec_t v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic idx_t next_idx(input idx_t i);
    return (int'(i) == NUM_MASTERS - 1) ? '0 : i + idx_t'(1);
  endfunction

  // First asserted request at or after start, wrapping modulo NUM_MASTERS.
  function automatic logic pick(input vec_t req, input idx_t start, output idx_t win);
    idx_t idx   = start;
    logic found = 1'b0;
    win = start;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
      idx = next_idx(idx);
    end
    return found;
  endfunction

  state_e         state_q, state_d;
  vec_t           grant_q, grant_d;
  idx_t           master_q, master_d;
  logic           lock_q, lock_d;
  logic [HW-1:0]  hold_q, hold_d;
  idx_t           rr_q, rr_d;
  idx_t           downer_q;
  logic           dvalid_q;

  vec_t           req, others_v;
  logic           others, found;
  idx_t           win;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d  = state_q;
    grant_d  = grant_q;
    master_d = master_q;
    lock_d   = lock_q;
    hold_d   = hold_q;
    rr_d     = rr_q;
    found    = 1'b0;
    win      = '0;
    req      = bus.HReq_m;
    others_v = req & ~onehot(master_q);
    others   = |others_v;

    unique case (state_q)
      IDLE: begin
        found = pick(req, rr_q, win);
        if (found) begin
          grant_d  = onehot(win);
          master_d = win;
          lock_d   = bus.HLock_m[win];
          hold_d   = '0;
          state_d  = OWNED;
        end
      end
      OWNED: begin
        if (bus.HLock_m[master_q]) begin
          lock_d = 1'b1;
        end else if (req[master_q] && (!others || hold_q < HW'(MAX_HOLD - 1))) begin
          hold_d = others ? hold_q + HW'(1) : '0;
          lock_d = 1'b0;
        end else begin
          // The owner is never a candidate here: it either dropped its request or its hold expired.
          rr_d  = next_idx(master_q);
          found = pick(others_v, next_idx(master_q), win);
          if (found) begin
            grant_d  = onehot(win);
            master_d = win;
            lock_d   = bus.HLock_m[win];
            hold_d   = '0;
          end else begin
            grant_d = '0;
            lock_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      master_q <= '0;
      lock_q   <= 1'b0;
      hold_q   <= '0;
      rr_q     <= '0;
      downer_q <= '0;
      dvalid_q <= 1'b0;
    end else if (bus.HReady) begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      master_q <= master_d;
      lock_q   <= lock_d;
      hold_q   <= hold_d;
      rr_q     <= rr_d;
      downer_q <= master_q;
      dvalid_q <= |grant_q;
    end
  end

  logic granted;
  assign granted = |grant_q;

  assign bus.HGrant      = grant_q;
  assign bus.HMaster     = master_q;
  assign bus.HMastLock   = lock_q;
  assign bus.HAddress    = granted ? bus.HAddress_m[int'(master_q)*32 +: 32] : 32'h0;
  assign bus.HTrans      = granted ? bus.HTrans_m[int'(master_q)*TB +: TB] : TB'(0);
  assign bus.HSize       = granted ? bus.HSize_m[int'(master_q)*SB +: SB] : SB'(2);
  assign bus.HWrite      = granted ? bus.HWrite_m[master_q] : 1'b0;
  assign bus.HWrite_data = dvalid_q ? bus.HWrite_data_m[int'(downer_q)*32 +: 32] : 32'h0;
endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
- Shares the single AHB-Lite style system bus between the CPU-side bus masters (instruction-memory wrapper, data-memory wrapper, future DMA).
- Grants bus ownership round-robin, honours locked transfers and caps how long one master may hold the bus.
- Muxes the granted master's address/control and the data-phase master's write data onto the shared slave-side bus.
- Sits between the master wrappers and the address decoder/slave mux.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8).
- MAX_HOLD, 16, maximum consecutive granted address phases for one master while others request (ignored while locked).
- MW, $clog2(NUM_MASTERS), master index width.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- HReq_m  input  NUM_MASTERS  per-master bus request
- HLock_m  input  NUM_MASTERS  per-master lock request
- HAddress_m  input  32*NUM_MASTERS  flattened per-master address; master i occupies bits [32i+31:32i]
- HTrans_m  input  `AHB_TRANS_BITS*NUM_MASTERS  per-master transfer type
- HSize_m  input  `AHB_SIZE_BITS*NUM_MASTERS  per-master size
- HWrite_m  input  NUM_MASTERS  per-master write flag
- HWrite_data_m  input  32*NUM_MASTERS  per-master write data
- HReady  input  1  shared transfer-done from slave mux
- HGrant  output  NUM_MASTERS  one-hot grant, or all zero
- HMaster  output  MW  address-phase owner index
- HMastLock  output  1  current address phase is locked
- HAddress  output  32  muxed address
- HTrans  output  `AHB_TRANS_BITS  muxed transfer type
- HSize  output  `AHB_SIZE_BITS  muxed size
- HWrite  output  1  muxed write flag
- HWrite_data  output  32  write data of data-phase owner

Behaviour:
- Reset (rst=1 at posedge) sets HGrant=0, HMaster=0, HMastLock=0, data-phase owner=0, rr_ptr=0, hold_cnt=0 and state=IDLE.
- Reset overrides any transfer in progress. Grant drops on the edge where rst is sampled.
- Combinational outputs while no grant: HTrans=2'b00 (IDLE), HAddress=0, HSize=3'b010, HWrite=0.
- All grant/state updates occur only on posedges with HReady=1. With HReady=0, HGrant, HMaster, HMastLock, hold_cnt, rr_ptr and state all hold.
- Winner selection: the first asserted HReq_m index, searching upward from rr_ptr and wrapping modulo NUM_MASTERS.
- FSM IDLE:
  - If any HReq_m is set, grant the winner: HGrant<=onehot(w), HMaster<=w, HMastLock<=HLock_m[w], hold_cnt<=0, go to OWNED.
  - Otherwise stay in IDLE with HGrant=0.
- FSM OWNED, owner o, evaluated in priority order:
  - (1) HLock_m[o]=1: keep grant; hold_cnt unchanged.
  - (2) HReq_m[o]=1 and (no other request, or hold_cnt<MAX_HOLD-1): keep grant; hold_cnt++ only when another master requests, else hold_cnt<=0.
  - (3) Otherwise release: rr_ptr<=(o+1) mod NUM_MASTERS.
    - Choose a winner from the remaining requests, excluding o if the hold expired while others request.
    - If a winner exists, grant it with hold_cnt<=0 and stay in OWNED.
    - If none remain, HGrant<=0 and go to IDLE.
- Handover latency: one HReady-qualified edge. An owner deasserting HReq loses HGrant on the next HReady=1 edge, and the new grant is visible in the same cycle.
- Grant is never given to a master with HReq_m=0. There is no default-master parking.
- Address/control outputs: when HGrant≠0, they are the HMaster slice of the per-master buses, passed through combinationally.
- Data-phase owner: on each HReady=1 edge, the data-phase owner<=HMaster and data_valid<=(HGrant≠0). HWrite_data is the data-phase owner's slice if data_valid, else 0.
- HMastLock is registered alongside the grant.
- Simultaneous requests from all masters with no lock give strict rotation of grants, at most MAX_HOLD phases each.
- rr_ptr wraps from NUM_MASTERS-1 to 0.

Test Plan:
- Single master: reset, then HReq_m=2'b01 with HReady=1 → HGrant=01 and HMaster=0 after 1 edge. Drop the request → HGrant=00, HTrans=00 next edge.
- Contention: HReq_m=2'b11 held, MAX_HOLD=4, HReady=1 → grant sequence 01×4, 10×4, 01×4… HMaster toggles every 4 cycles.
- Lock: master 0 granted with HLock_m[0]=1, master 1 requesting for 20 cycles → HGrant stays 01 and HMastLock=1. Drop the lock → HGrant=10 within 1 cycle.
- Wait states: HReady=0 for 5 cycles during handover → HGrant, HMaster and hold_cnt frozen. Handover completes on the first HReady=1 edge.
- Write data routing: master 1 issues a write (HAddress_m=0x0000_1000, data 0xDEAD_BEEF), then master 0 is granted → HWrite_data=0xDEAD_BEEF in the cycle after master 1's address phase while HAddress shows master 0.
- Reset mid-transfer: assert rst while HGrant=10 and hold_cnt=2 → the next edge gives HGrant=00 and all outputs at reset values. After release, the first grant goes to master 0 (rr_ptr=0).
